// File: rtl/student_schedule_fsm.sv
// student_schedule_fsm: daily-routine state machine for a student.
// Tracks energy, outstanding homework per course and a per-state dwell timer.
// The homework arbiter picks courses round-robin each time STUDY is entered.
module student_schedule_fsm #(
  parameter int NUM_COURSES = 4,
  parameter int ENERGY_W    = 6,
  parameter int ENERGY_MAX  = 40,
  parameter int WAKE_LEVEL  = 20,
  parameter int DWELL       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alarm,
  input  logic                           bus_arrive,
  input  logic                           hungry,
  input  logic                           class_time,
  input  logic [NUM_COURSES-1:0]         hw_assign,
  input  logic                           design_work,
  input  logic                           brain_no_work,
  output logic [3:0]                     state_out,
  output logic [ENERGY_W-1:0]            energy,
  output logic [NUM_COURSES-1:0]         hw_pending,
  output logic [$clog2(NUM_COURSES)-1:0] course_sel,
  output logic                           day_done
);

  localparam int CS_W = $clog2(NUM_COURSES);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [3:0] {
    SLEEP       = 4'd0,
    EAT         = 4'd1,
    BUS         = 4'd2,
    LECTURE     = 4'd3,
    TIM_HORTONS = 4'd4,
    STUDY       = 4'd5,
    DESIGN_TEAM = 4'd6,
    NETFLIX     = 4'd7,
    GYM         = 4'd8,
    SOCIALIZE   = 4'd9
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [DW_W-1:0]        dwell;
  logic                   dwell_done;
  logic                   restudy;
  logic                   enter;
  logic [NUM_COURSES-1:0] cur_mask;
  logic [NUM_COURSES-1:0] others;
  logic [NUM_COURSES-1:0] clear_bits;
  logic [NUM_COURSES-1:0] search_vec;
  logic [CS_W-1:0]        next_sel;
  logic [ENERGY_W-1:0]    next_energy;

  assign state_out  = state;
  assign dwell_done = (dwell == DW_W'(DWELL - 1));
  assign enter      = (next_state != state) || restudy;

  // Next-state decision: an empty energy tank overrides everything, then the per-state rules
  always_comb begin
    next_state = SLEEP;
    restudy    = 1'b0;
    clear_bits = '0;
    day_done   = 1'b0;
    cur_mask   = '0;
    cur_mask[course_sel] = 1'b1;
    others     = hw_pending & ~cur_mask;
    if (state != SLEEP && energy == '0) begin
      next_state = SLEEP;
    end else begin
      case (state)
        SLEEP:
          next_state = (alarm && energy >= ENERGY_W'(WAKE_LEVEL)) ? EAT : SLEEP;
        EAT:
          if (!dwell_done)       next_state = EAT;
          else if (class_time)   next_state = BUS;
          else if (|hw_pending)  next_state = STUDY;
          else                   next_state = NETFLIX;
        BUS:
          next_state = bus_arrive ? LECTURE : BUS;
        LECTURE:
          if (!dwell_done)       next_state = LECTURE;
          else if (hungry)       next_state = TIM_HORTONS;
          else if (|hw_pending)  next_state = STUDY;
          else if (design_work)  next_state = DESIGN_TEAM;
          else                   next_state = SOCIALIZE;
        TIM_HORTONS:
          if (!dwell_done)       next_state = TIM_HORTONS;
          else if (|hw_pending)  next_state = STUDY;
          else                   next_state = SOCIALIZE;
        STUDY:
          if (brain_no_work) begin
            next_state = NETFLIX;
          end else if (dwell_done) begin
            clear_bits = cur_mask;
            if (|others) begin
              next_state = STUDY;
              restudy    = 1'b1;
            end else if (design_work) begin
              next_state = DESIGN_TEAM;
            end else begin
              next_state = GYM;
            end
          end else begin
            next_state = STUDY;
          end
        DESIGN_TEAM:
          next_state = dwell_done ? GYM : DESIGN_TEAM;
        GYM:
          if (!dwell_done)       next_state = GYM;
          else if (hungry)       next_state = EAT;
          else                   next_state = SOCIALIZE;
        SOCIALIZE:
          next_state = dwell_done ? NETFLIX : SOCIALIZE;
        NETFLIX:
          next_state = dwell_done ? SLEEP : NETFLIX;
        default:
          next_state = SLEEP;
      endcase
    end
    if (state == NETFLIX && next_state == SLEEP) begin
      day_done = 1'b1;
    end
  end

  // Round-robin pick of the next pending course, starting just after the current one
  always_comb begin
    int idx;
    logic found;
    next_sel   = course_sel;
    found      = 1'b0;
    search_vec = (state == STUDY) ? others : hw_pending;
    for (int i = 1; i <= NUM_COURSES; i++) begin
      idx = (int'(course_sel) + i) % NUM_COURSES;
      if (!found && search_vec[idx]) begin
        next_sel = CS_W'(idx);
        found    = 1'b1;
      end
    end
  end

  // Energy gain or drain for the current activity, clamped to [0, ENERGY_MAX]
  always_comb begin
    int delta;
    int sum;
    case (state)
      SLEEP:            delta = 2;
      EAT, TIM_HORTONS: delta = 1;
      GYM:              delta = -2;
      default:          delta = -1;
    endcase
    sum = int'(energy) + delta;
    if (sum < 0)               next_energy = '0;
    else if (sum > ENERGY_MAX) next_energy = ENERGY_W'(ENERGY_MAX);
    else                       next_energy = ENERGY_W'(sum);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SLEEP;
    else     state <= next_state;
  end

  // Dwell timer restarts on every state entry and saturates once the dwell is served
  always_ff @(posedge clk) begin
    if (rst)              dwell <= '0;
    else if (enter)       dwell <= '0;
    else if (!dwell_done) dwell <= dwell + 1'b1;
  end

  // Energy register
  always_ff @(posedge clk) begin
    if (rst) energy <= ENERGY_W'(ENERGY_MAX);
    else     energy <= next_energy;
  end

  // Homework bookkeeping: new assignments win over the clear of a finished course
  always_ff @(posedge clk) begin
    if (rst) hw_pending <= '0;
    else     hw_pending <= (hw_pending & ~clear_bits) | hw_assign;
  end

  // Course selection is latched only when STUDY is (re)entered
  always_ff @(posedge clk) begin
    if (rst)                              course_sel <= '0;
    else if (enter && next_state == STUDY) course_sel <= next_sel;
  end

endmodule

// File: tb/tb_student_schedule_fsm.sv
// tb_student_schedule_fsm: directed bench with an expectation scoreboard.
// Expected outputs are queued as each stimulus step is driven and compared
// one cycle-batch later, #1 after the clock edge.
module tb_student_schedule_fsm;

  localparam logic [3:0] S_SLEEP   = 4'd0;
  localparam logic [3:0] S_EAT     = 4'd1;
  localparam logic [3:0] S_BUS     = 4'd2;
  localparam logic [3:0] S_LECTURE = 4'd3;
  localparam logic [3:0] S_STUDY   = 4'd5;
  localparam logic [3:0] S_DESIGN  = 4'd6;
  localparam logic [3:0] S_NETFLIX = 4'd7;
  localparam logic [3:0] S_GYM     = 4'd8;

  logic       clk;
  logic       rst;
  logic       alarm;
  logic       bus_arrive;
  logic       hungry;
  logic       class_time;
  logic [3:0] hw_assign;
  logic       design_work;
  logic       brain_no_work;
  logic [3:0] state_out;
  logic [5:0] energy;
  logic [3:0] hw_pending;
  logic [1:0] course_sel;
  logic       day_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [5:0] en;
    logic [3:0] pend;
    logic [1:0] cs;
    logic       dd;
  } exp_t;

  exp_t sb[$];

  student_schedule_fsm #(
    .NUM_COURSES(4),
    .ENERGY_W(6),
    .ENERGY_MAX(40),
    .WAKE_LEVEL(20),
    .DWELL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alarm(alarm),
    .bus_arrive(bus_arrive),
    .hungry(hungry),
    .class_time(class_time),
    .hw_assign(hw_assign),
    .design_work(design_work),
    .brain_no_work(brain_no_work),
    .state_out(state_out),
    .energy(energy),
    .hw_pending(hw_pending),
    .course_sel(course_sel),
    .day_done(day_done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic a, input logic b, input logic h, input logic c,
                               input logic [3:0] hw, input logic d, input logic br);
    alarm         = a;
    bus_arrive    = b;
    hungry        = h;
    class_time    = c;
    hw_assign     = hw;
    design_work   = d;
    brain_no_work = br;
  endtask

  task automatic pushExp(input string tag, input logic [3:0] st, input logic [5:0] en,
                         input logic [3:0] pend, input logic [1:0] cs, input logic dd);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.en   = en;
    e.pend = pend;
    e.cs   = cs;
    e.dd   = dd;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (state_out === e.st) else begin
        errors++;
        $error("[TB] FAIL %s state_out: observed %0d expected %0d", e.tag, state_out, e.st);
      end
      checks++;
      assert (energy === e.en) else begin
        errors++;
        $error("[TB] FAIL %s energy: observed %0d expected %0d", e.tag, energy, e.en);
      end
      checks++;
      assert (hw_pending === e.pend) else begin
        errors++;
        $error("[TB] FAIL %s hw_pending: observed %b expected %b", e.tag, hw_pending, e.pend);
      end
      checks++;
      assert (course_sel === e.cs) else begin
        errors++;
        $error("[TB] FAIL %s course_sel: observed %0d expected %0d", e.tag, course_sel, e.cs);
      end
      checks++;
      assert (day_done === e.dd) else begin
        errors++;
        $error("[TB] FAIL %s day_done: observed %b expected %b", e.tag, day_done, e.dd);
      end
    end
  endtask

  // Directed scenario: two simulated days covering wake-up, lectures, study arbitration,
  // mid-activity reset, energy exhaustion and the end-of-day pulse
  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("reset", S_SLEEP, 6'd40, 4'b0000, 2'd0, 1'b0);
    step(2); checkOutput();

    $display("[TB] day 1: wake, bus, lecture, study round-robin");
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("wake", S_EAT, 6'd40, 4'b0000, 2'd0, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 1, 4'b0000, 0, 0);
    pushExp("eat_hold", S_EAT, 6'd40, 4'b0000, 2'd0, 1'b0);
    step(3); checkOutput();
    pushExp("to_bus", S_BUS, 6'd40, 4'b0000, 2'd0, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("bus_wait", S_BUS, 6'd38, 4'b0000, 2'd0, 1'b0);
    step(2); checkOutput();
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0);
    pushExp("to_lecture", S_LECTURE, 6'd37, 4'b0000, 2'd0, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b1010, 0, 0);
    pushExp("assign", S_LECTURE, 6'd36, 4'b1010, 2'd0, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("to_study", S_STUDY, 6'd33, 4'b1010, 2'd1, 1'b0);
    step(3); checkOutput();
    pushExp("restudy", S_STUDY, 6'd29, 4'b1000, 2'd3, 1'b0);
    step(4); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 1, 0);
    pushExp("to_design", S_DESIGN, 6'd25, 4'b0000, 2'd3, 1'b0);
    step(4); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0001, 1, 0);
    pushExp("dt_assign", S_DESIGN, 6'd24, 4'b0001, 2'd3, 1'b0);
    step(1); checkOutput();
    rst = 1'b1;
    applyStimulus(1, 1, 1, 1, 4'b1111, 1, 1);
    pushExp("mid_reset", S_SLEEP, 6'd40, 4'b0000, 2'd0, 1'b0);
    step(1); checkOutput();

    $display("[TB] day 2: energy drain, set/clear collision, forced sleep, abort");
    rst = 1'b0;
    applyStimulus(1, 0, 0, 1, 4'b1000, 0, 0);
    pushExp("wake2", S_EAT, 6'd40, 4'b1000, 2'd0, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 1, 4'b0000, 0, 0);
    pushExp("to_bus2", S_BUS, 6'd40, 4'b1000, 2'd0, 1'b0);
    step(4); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("bus_drain", S_BUS, 6'd13, 4'b1000, 2'd0, 1'b0);
    step(27); checkOutput();
    applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0);
    pushExp("to_lecture2", S_LECTURE, 6'd12, 4'b1000, 2'd0, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("to_study2", S_STUDY, 6'd8, 4'b1000, 2'd3, 1'b0);
    step(4); checkOutput();
    pushExp("study_d3", S_STUDY, 6'd5, 4'b1000, 2'd3, 1'b0);
    step(3); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b1000, 0, 0);
    pushExp("set_clear", S_GYM, 6'd4, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("gym_d1", S_GYM, 6'd2, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    pushExp("gym_zero", S_GYM, 6'd0, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    pushExp("forced_sleep", S_SLEEP, 6'd0, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    pushExp("sleep_wait", S_SLEEP, 6'd20, 4'b1000, 2'd3, 1'b0);
    step(10); checkOutput();
    pushExp("wake3", S_EAT, 6'd22, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("to_study3", S_STUDY, 6'd26, 4'b1000, 2'd3, 1'b0);
    step(4); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 1);
    pushExp("abort", S_NETFLIX, 6'd25, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    pushExp("nf_d2", S_NETFLIX, 6'd23, 4'b1000, 2'd3, 1'b0);
    step(2); checkOutput();
    pushExp("nf_done", S_NETFLIX, 6'd22, 4'b1000, 2'd3, 1'b1);
    step(1); checkOutput();
    pushExp("day_end", S_SLEEP, 6'd21, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();
    pushExp("sleep_stay", S_SLEEP, 6'd23, 4'b1000, 2'd3, 1'b0);
    step(1); checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/student_schedule_fsm.md
STUDENT_SCHEDULE_FSM -- requirements
Module: student_schedule_fsm

Interface
REQ-001 SHALL have parameter NUM_COURSES, default 4, number of course homework channels (>=2).
REQ-002 SHALL have parameter ENERGY_W, default 6, energy counter width.
REQ-003 SHALL have parameter ENERGY_MAX, default 40, energy ceiling (< 2^ENERGY_W).
REQ-004 SHALL have parameter WAKE_LEVEL, default 20, minimum energy to leave SLEEP.
REQ-005 SHALL have parameter DWELL, default 4, minimum cycles spent in a timed state (>=1).
REQ-006 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port alarm  in  1  wake request.
REQ-009 SHALL have port bus_arrive  in  1  bus present.
REQ-010 SHALL have port hungry  in  1  hunger flag.
REQ-011 SHALL have port class_time  in  1  class scheduled.
REQ-012 SHALL have port hw_assign  in  NUM_COURSES  per-course homework-assign pulses.
REQ-013 SHALL have port design_work  in  1  design team task pending.
REQ-014 SHALL have port brain_no_work  in  1  study abort.
REQ-015 SHALL have port state_out  out  4  current state code.
REQ-016 SHALL have port energy  out  ENERGY_W  current energy.
REQ-017 SHALL have port hw_pending  out  NUM_COURSES  outstanding homework bitmask.
REQ-018 SHALL have port course_sel  out  $clog2(NUM_COURSES)  course being studied.
REQ-019 SHALL have port day_done  out  1  one-cycle pulse on NETFLIX->SLEEP.

Function
REQ-020 SHALL encode states SLEEP=0, EAT=1, BUS=2, LECTURE=3, TIM_HORTONS=4, STUDY=5, DESIGN_TEAM=6, NETFLIX=7, GYM=8, SOCIALIZE=9; codes 10-15 SHALL go to SLEEP next cycle.
REQ-021 SHALL keep dwell counter: 0 on every state entry, +1 per cycle while staying, saturating; "dwell done" = counter == DWELL-1; SLEEP and BUS untimed.
REQ-022 SHALL update energy per cycle, saturating at 0 and ENERGY_MAX: SLEEP +2; EAT, TIM_HORTONS +1; GYM -2; all other states -1.
REQ-023 SHALL force next state SLEEP from any non-SLEEP state when energy == 0; highest priority.
REQ-024 SLEEP: alarm && energy >= WAKE_LEVEL -> EAT; else stay.
REQ-025 EAT on dwell done: class_time -> BUS; else |hw_pending -> STUDY; else NETFLIX.
REQ-026 BUS: bus_arrive -> LECTURE; else stay, no timeout.
REQ-027 LECTURE on dwell done: hungry -> TIM_HORTONS; else |hw_pending -> STUDY; else design_work -> DESIGN_TEAM; else SOCIALIZE.
REQ-028 TIM_HORTONS on dwell done: |hw_pending -> STUDY; else SOCIALIZE.
REQ-029 STUDY: brain_no_work -> NETFLIX immediately, no bit cleared; priority over dwell done.
REQ-030 STUDY on dwell done: clear hw_pending[course_sel]; other bits pending -> re-enter STUDY (dwell restarts); else design_work -> DESIGN_TEAM; else GYM.
REQ-031 DESIGN_TEAM on dwell done -> GYM; GYM on dwell done: hungry -> EAT, else SOCIALIZE; SOCIALIZE on dwell done -> NETFLIX; NETFLIX on dwell done -> SLEEP with day_done=1 for that cycle.
REQ-032 SHALL set hw_pending[i] on hw_assign[i] in any state; simultaneous set and clear of same bit leaves it set.
REQ-033 SHALL load course_sel on every STUDY entry with first pending index after previous course_sel, round-robin, wrapping NUM_COURSES-1 -> 0.

Reset
REQ-034 rst SHALL give next cycle: state SLEEP, energy ENERGY_MAX, hw_pending 0, course_sel 0, dwell 0, day_done 0; overrides all inputs, including mid-STUDY.

Verification
REQ-035 Defaults; reset, alarm=1 -> EAT next cycle; energy 40 throughout EAT (saturated +1); after 4 cycles class_time=1 -> BUS.
REQ-036 hw_assign=4'b1010 in LECTURE, hungry=0 -> STUDY course_sel=1, clears bit1 after 4 cycles, re-enters STUDY course_sel=3, then hw_pending=0.
REQ-037 STUDY course_sel=3, hw_assign[3] pulsed on clearing cycle -> hw_pending[3] remains 1.
REQ-038 brain_no_work=1 in STUDY -> NETFLIX next cycle, hw_pending unchanged; after 4 cycles SLEEP with day_done pulse.
REQ-039 Energy driven to 0 in GYM -> SLEEP next cycle; alarm held -> stay SLEEP until energy >= 20 (10 cycles), then EAT.
REQ-040 rst asserted mid-DESIGN_TEAM -> all outputs at reset values next cycle.
